id_ex_src1_stage: RTL and testbench

//  ID/EX pipeline register for the ALU/shifter source-1 path, plus forwarding-select generation and

---
 rtl/id_ex_src1_stage.sv | 98 +++++++++
 tb/tb_id_ex_src1_stage.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/id_ex_src1_stage.sv
// ID/EX register for the source-1 operand path: latches decoded src1 fields, generates the
// registered EX source-1 mux select with EX/MEM forwarding, and detects load-use hazards.
module id_ex_src1_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int IMM_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [1:0]        id_src1_kind,
    input  logic [DATA_W-1:0] id_p1,
    input  logic [IMM_W-1:0]  id_imm,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_we,
    input  logic              id_load,
    input  logic              flush,
    output logic              stall_o,
    output logic              ex_valid,
    output logic [2:0]        ex_src1sel,
    output logic [DATA_W-1:0] ex_p1,
    output logic [IMM_W-1:0]  ex_imm,
    output logic [DATA_W-1:0] ex_pc,
    output logic [REG_AW-1:0] ex_dst,
    output logic              ex_we,
    output logic              ex_load
);

    localparam logic [2:0] SEL_FWD_MEM = 3'b100;
    // Both ALU (bit1) and shifter (bit0) muxes must see the EX forward, hence all ones.
    localparam logic [2:0] SEL_FWD_EX  = 3'b111;

    logic [REG_AW-1:0] mem_dst;
    logic              mem_we;
    logic              rs1_is_reg;
    logic              hit_e;
    logic              hit_m;
    logic              bubble;
    logic [2:0]        next_sel;

    // Register 0 reads as zero and immediates/pc never need forwarding.
    assign rs1_is_reg = (id_src1_kind == 2'b00) && (id_rs1 != '0);
    assign hit_e      = rs1_is_reg && ex_valid && ex_we && (ex_dst == id_rs1);
    assign hit_m      = rs1_is_reg && mem_we && (mem_dst == id_rs1);
    assign stall_o    = id_valid && hit_e && ex_load && !flush;
    assign bubble     = flush || stall_o;

    always_comb begin
        next_sel = {1'b0, id_src1_kind};
        if (hit_e) begin
            next_sel = SEL_FWD_EX;
        end else if (hit_m) begin
            next_sel = SEL_FWD_MEM;
        end
    end

    // EX/MEM shadow of the instruction leaving EX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_dst <= '0;
            mem_we  <= 1'b0;
        end else begin
            mem_dst <= ex_dst;
            mem_we  <= ex_we && ex_valid;
        end
    end

    // ID -> EX transfer; a bubble clears only the flags, data fields keep stale values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_src1sel <= 3'b000;
            ex_we      <= 1'b0;
            ex_load    <= 1'b0;
            ex_p1      <= '0;
            ex_imm     <= '0;
            ex_pc      <= '0;
            ex_dst     <= '0;
        end else if (bubble) begin
            ex_valid   <= 1'b0;
            ex_src1sel <= 3'b000;
            ex_we      <= 1'b0;
            ex_load    <= 1'b0;
        end else begin
            ex_valid   <= id_valid;
            ex_src1sel <= next_sel;
            ex_we      <= id_we && id_valid;
            ex_load    <= id_load && id_valid;
            ex_p1      <= id_p1;
            ex_imm     <= id_imm;
            ex_pc      <= id_pc;
            ex_dst     <= id_dst;
        end
    end

endmodule

// File: tb/tb_id_ex_src1_stage.sv
// Directed bench for id_ex_src1_stage: forwarding selects, load-use stall, flush and reset.
module tb_id_ex_src1_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [3:0]  id_rs1;
    logic [1:0]  id_src1_kind;
    logic [15:0] id_p1;
    logic [7:0]  id_imm;
    logic [15:0] id_pc;
    logic [3:0]  id_dst;
    logic        id_we;
    logic        id_load;
    logic        flush;
    logic        stall_o;
    logic        ex_valid;
    logic [2:0]  ex_src1sel;
    logic [15:0] ex_p1;
    logic [7:0]  ex_imm;
    logic [15:0] ex_pc;
    logic [3:0]  ex_dst;
    logic        ex_we;
    logic        ex_load;

    int total = 0;
    int fails = 0;

    id_ex_src1_stage #(.DATA_W(16), .REG_AW(4), .IMM_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1),
        .id_src1_kind(id_src1_kind), .id_p1(id_p1), .id_imm(id_imm), .id_pc(id_pc),
        .id_dst(id_dst), .id_we(id_we), .id_load(id_load), .flush(flush),
        .stall_o(stall_o), .ex_valid(ex_valid), .ex_src1sel(ex_src1sel), .ex_p1(ex_p1),
        .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_dst(ex_dst), .ex_we(ex_we), .ex_load(ex_load)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic instr(input logic v, input logic [3:0] rs1, input logic [1:0] kind,
                         input logic [15:0] p1, input logic [7:0] imm, input logic [15:0] pc,
                         input logic [3:0] dst, input logic we, input logic ld);
        id_valid = v; id_rs1 = rs1; id_src1_kind = kind; id_p1 = p1; id_imm = imm;
        id_pc = pc; id_dst = dst; id_we = we; id_load = ld;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, {31'd0, stall_o}, 32'd0);
        chk({tag, "_valid"}, {31'd0, ex_valid}, 32'd0);
        chk({tag, "_sel"}, {29'd0, ex_src1sel}, 32'd0);
        chk({tag, "_p1"}, {16'd0, ex_p1}, 32'd0);
        chk({tag, "_imm"}, {24'd0, ex_imm}, 32'd0);
        chk({tag, "_pc"}, {16'd0, ex_pc}, 32'd0);
        chk({tag, "_dst"}, {28'd0, ex_dst}, 32'd0);
        chk({tag, "_we"}, {31'd0, ex_we}, 32'd0);
        chk({tag, "_load"}, {31'd0, ex_load}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk_all_zero("rst_init");
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_release_valid", {31'd0, ex_valid}, 32'd0);

        // ADD r3 then SUB rs1=r3 back-to-back
        instr(1, 4'd1, 2'b00, 16'h1111, 8'h00, 16'h0010, 4'd3, 1, 0);
        tick();
        chk("add_valid", {31'd0, ex_valid}, 32'd1);
        chk("add_sel", {29'd0, ex_src1sel}, 32'd0);
        chk("add_p1", {16'd0, ex_p1}, 32'h1111);
        chk("add_pc", {16'd0, ex_pc}, 32'h0010);
        chk("add_dst", {28'd0, ex_dst}, 32'd3);
        chk("add_we", {31'd0, ex_we}, 32'd1);
        instr(1, 4'd3, 2'b00, 16'h2222, 8'h00, 16'h0011, 4'd4, 1, 0);
        chk("sub_no_stall", {31'd0, stall_o}, 32'd0);
        tick();
        chk("sub_fwd_ex", {29'd0, ex_src1sel}, 32'd7);

        // ADD r3, NOP, SUB r3 -> MEM forward
        instr(1, 4'd0, 2'b00, 16'h0000, 8'h00, 16'h0012, 4'd3, 1, 0);
        tick();
        instr(0, 4'd0, 2'b00, 16'h0000, 8'h00, 16'h0013, 4'd0, 0, 0);
        tick();
        chk("nop_valid", {31'd0, ex_valid}, 32'd0);
        chk("nop_we", {31'd0, ex_we}, 32'd0);
        instr(1, 4'd3, 2'b00, 16'h3333, 8'h00, 16'h0014, 4'd8, 0, 0);
        tick();
        chk("sub_fwd_mem", {29'd0, ex_src1sel}, 32'd4);

        // ADD r3, ADD r3, SUB r3 -> EX forward has priority
        instr(1, 4'd0, 2'b00, 16'h0000, 8'h00, 16'h0015, 4'd3, 1, 0);
        tick();
        instr(1, 4'd0, 2'b00, 16'h0000, 8'h00, 16'h0016, 4'd3, 1, 0);
        tick();
        instr(1, 4'd3, 2'b00, 16'h4444, 8'h00, 16'h0017, 4'd9, 1, 0);
        chk("prio_no_stall", {31'd0, stall_o}, 32'd0);
        tick();
        chk("prio_fwd_ex", {29'd0, ex_src1sel}, 32'd7);

        // LW r5 then ADD rs1=r5 -> one stall cycle, bubble, then MEM forward
        instr(1, 4'd0, 2'b00, 16'h0000, 8'h00, 16'h0020, 4'd5, 1, 1);
        tick();
        chk("lw_load", {31'd0, ex_load}, 32'd1);
        instr(1, 4'd5, 2'b00, 16'h5555, 8'h00, 16'h0021, 4'd6, 1, 0);
        chk("lu_stall", {31'd0, stall_o}, 32'd1);
        tick();
        chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("lu_bubble_we", {31'd0, ex_we}, 32'd0);
        chk("lu_bubble_load", {31'd0, ex_load}, 32'd0);
        chk("lu_bubble_sel", {29'd0, ex_src1sel}, 32'd0);
        chk("lu_stall_drop", {31'd0, stall_o}, 32'd0);
        tick();
        chk("lu_after_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu_after_sel", {29'd0, ex_src1sel}, 32'd4);
        chk("lu_after_p1", {16'd0, ex_p1}, 32'h5555);

        // r0 is never forwarded; pc+1 source ignores a matching rs1
        instr(1, 4'd0, 2'b00, 16'h0000, 8'h00, 16'h0030, 4'd0, 1, 0);
        tick();
        instr(1, 4'd0, 2'b00, 16'h0000, 8'h00, 16'h0031, 4'd7, 1, 1);
        tick();
        chk("r0_sel", {29'd0, ex_src1sel}, 32'd0);
        instr(1, 4'd7, 2'b11, 16'h0000, 8'h00, 16'h1234, 4'd2, 1, 0);
        chk("pc_no_stall", {31'd0, stall_o}, 32'd0);
        tick();
        chk("pc_sel", {29'd0, ex_src1sel}, 32'd3);
        chk("pc_val", {16'd0, ex_pc}, 32'h1234);

        // flush with load-use pending, then imm8 0x80
        instr(1, 4'd0, 2'b00, 16'h0000, 8'h00, 16'h0040, 4'd5, 1, 1);
        tick();
        instr(1, 4'd5, 2'b00, 16'h6666, 8'h00, 16'h0041, 4'd6, 1, 0);
        flush = 1'b1;
        #1;
        chk("flush_no_stall", {31'd0, stall_o}, 32'd0);
        tick();
        flush = 1'b0;
        chk("flush_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush_we", {31'd0, ex_we}, 32'd0);
        instr(1, 4'd5, 2'b01, 16'h0000, 8'h80, 16'h0042, 4'd1, 1, 0);
        chk("imm8_no_stall", {31'd0, stall_o}, 32'd0);
        tick();
        chk("imm8_sel", {29'd0, ex_src1sel}, 32'd1);
        chk("imm8_val", {24'd0, ex_imm}, 32'h80);

        // asynchronous reset in the middle of a load-use stall
        instr(1, 4'd0, 2'b00, 16'h0000, 8'h00, 16'h0050, 4'd5, 1, 1);
        tick();
        instr(1, 4'd5, 2'b00, 16'h7777, 8'h00, 16'h0051, 4'd6, 1, 0);
        chk("mid_stall", {31'd0, stall_o}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_async");
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst2_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst2_stall", {31'd0, stall_o}, 32'd0);
        tick();
        chk("rst2_restart_sel", {29'd0, ex_src1sel}, 32'd0);
        chk("rst2_restart_valid", {31'd0, ex_valid}, 32'd1);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
